crc32_frame_append: RTL and testbench

Transmit-side framing stage that sits directly upstream of the 32-bit CRC-32 checker path. It accepts a stream of 32-bit payload words delimited by `s_last` and forwards them through a one-deep output register. After each frame it appends one CRC word equal to the CRC-32 register state (poly 0x04C11DB7, per-word update, no final XOR) over that frame's payload. A downstream 32-bit CRC engine seeded with the same `CRC_INIT` therefore reaches a residue of exactly 0x00000000 after consuming payload plus appended word.

---
 rtl/crc32_pkg.sv | 24 ++
 rtl/crc32_out_reg.sv | 46 ++++
 rtl/crc32_frame_append.sv | 85 ++++++++
 tb/tb_crc32_frame_append.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the frame-append stage and any checker that
// must use identical update equations.
package crc32_pkg;

   localparam logic [31:0] CRC32_POLY         = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_INIT_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic {
      ST_PAYLOAD = 1'b0,
      ST_CRC     = 1'b1
   } state_e;

   // 32-bit-parallel MSB-first update. Because the data width equals the register
   // width, the result depends only on (c ^ d), so crc32_next(c, c) == 0.
   function automatic logic [31:0] crc32_next(input logic [31:0] c, input logic [31:0] d);
      logic [31:0] x;
      x = c ^ d;
      for (int i = 0; i < 32; i++) begin
         x = x[31] ? ((x << 1) ^ CRC32_POLY) : (x << 1);
      end
      return x;
   endfunction

endpackage

// File: rtl/crc32_out_reg.sv
// One-deep valid/ready output register. The owner only raises load when free
// is high; din packs {last, data}.
module crc32_out_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [32:0] din,
   output logic        free,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        m_last
);

   logic        valid_q, valid_d;
   logic [32:0] word_q, word_d;

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      free    = !valid_q || m_ready;
      valid_d = valid_q;
      word_d  = word_q;
      if (load) begin
         valid_d = 1'b1;
         word_d  = din;
      end else if (m_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         word_q  <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
      end
   end

   assign m_valid = valid_q;
   assign m_data  = word_q[31:0];
   assign m_last  = word_q[32];

endmodule

// File: rtl/crc32_frame_append.sv
// Forwards payload words and appends the running CRC-32 register after each
// frame, so a downstream engine with the same seed ends at a zero residue.
module crc32_frame_append
   import crc32_pkg::*;
#(
   parameter logic [31:0] CRC_INIT = CRC32_INIT_DEFAULT,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [31:0]      s_data,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [31:0]      m_data,
   output logic             m_last,
   output logic [CNT_W-1:0] frame_cnt
);

   state_e             state_q, state_d;
   logic [31:0]        crc_q, crc_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic               load;
   logic               free;
   logic [32:0]        din;

   always_comb begin
      state_d     = state_q;
      crc_d       = crc_q;
      frame_cnt_d = frame_cnt_q;
      load        = 1'b0;
      din         = '0;
      s_ready     = 1'b0;
      case (state_q)
         ST_PAYLOAD: begin
            s_ready = free;
            if (s_valid && free) begin
               load  = 1'b1;
               din   = {1'b0, s_data};
               crc_d = crc32_next(crc_q, s_data);
               if (s_last) state_d = ST_CRC;
            end
         end
         ST_CRC: begin
            // Reseeding on the same edge keeps this CRC out of the next frame.
            if (free) begin
               load        = 1'b1;
               din         = {1'b1, crc_q};
               crc_d       = CRC_INIT;
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               state_d     = ST_PAYLOAD;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_PAYLOAD;
         crc_q       <= CRC_INIT;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         crc_q       <= crc_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   crc32_out_reg u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .din     (din),
      .free    (free),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last)
   );

   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_crc32_frame_append.sv
// Self-checking bench for crc32_frame_append; the reference CRC is computed by
// polynomial long division rather than the shift-register form.
module tb_crc32_frame_append;

   localparam logic [31:0] INIT      = 32'hFFFF_FFFF;
   localparam logic [32:0] POLY_FULL = 33'h1_04C1_1DB7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        m_ready = 1'b1;
   logic        s_ready, m_valid, m_last;
   logic [31:0] m_data;
   logic [15:0] frame_cnt;
   logic        s_ready_w, m_valid_w, m_last_w;
   logic [31:0] m_data_w;
   logic [1:0]  frame_cnt_w;

   always #5 clk = ~clk;

   crc32_frame_append dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_last(m_last), .frame_cnt(frame_cnt)
   );

   crc32_frame_append #(.CNT_W(2)) dut_w (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_w), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid_w), .m_ready(m_ready), .m_data(m_data_w),
      .m_last(m_last_w), .frame_cnt(frame_cnt_w)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          exp_frames = 0;
   int          stall_start = -1;
   int          stall_len = 0;
   logic [32:0] rx_q[$];
   int          rx_cyc[$];
   logic        sr_q[$];
   logic [31:0] tx_data[$];
   logic        tx_last[$];
   logic [32:0] exp_q[$];
   logic [31:0] stage[$];
   logic        hold_pend = 1'b0;
   logic [32:0] held = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Remainder of ((c ^ d) * x^32) modulo the full degree-32 generator.
   function automatic logic [31:0] ref_step(input logic [31:0] c, input logic [31:0] d);
      logic [63:0] r;
      r = {c ^ d, 32'h0};
      for (int i = 63; i >= 32; i--) begin
         if (r[i]) r[i -: 33] = r[i -: 33] ^ POLY_FULL;
      end
      return r[31:0];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Beat collection plus the hold rule while the output is stalled.
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_pend) begin
            check("hold_valid", m_valid, 1'b1);
            check("hold_word", {m_last, m_data}, held);
         end
         if (m_valid && !m_ready) check("stall_s_ready", s_ready, 1'b0);
         hold_pend <= m_valid && !m_ready;
         held      <= {m_last, m_data};
         if (m_valid && m_ready) begin
            rx_q.push_back({m_last, m_data});
            rx_cyc.push_back(cyc);
         end
      end else begin
         hold_pend <= 1'b0;
      end
   end

   task automatic add_frame();
      logic [31:0] c;
      c = INIT;
      for (int i = 0; i < stage.size(); i++) begin
         tx_data.push_back(stage[i]);
         tx_last.push_back(i == stage.size() - 1);
         exp_q.push_back({1'b0, stage[i]});
         c = ref_step(c, stage[i]);
      end
      exp_q.push_back({1'b1, c});
      stage.delete();
   endtask

   task automatic random_stage(input int n);
      for (int i = 0; i < n; i++) stage.push_back($urandom());
   endtask

   task automatic clear_all();
      rx_q.delete(); rx_cyc.delete(); tx_data.delete(); tx_last.delete(); exp_q.delete();
   endtask

   task automatic drive(input int max_words, input int min_iters);
      int   idx;
      int   it;
      logic fire;
      idx = 0;
      it  = 0;
      sr_q.delete();
      while ((idx < max_words || it < min_iters) && it < 2000) begin
         s_valid = (idx < max_words);
         s_data  = s_valid ? tx_data[idx] : 32'h0;
         s_last  = s_valid ? tx_last[idx] : 1'b0;
         m_ready = !(it >= stall_start && it < stall_start + stall_len);
         @(negedge clk);
         fire = s_valid && s_ready;
         sr_q.push_back(s_ready);
         @(posedge clk);
         #1;
         if (fire) idx++;
         it++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      check("words_accepted", idx, max_words);
   endtask

   task automatic drain_and_compare(input string tag);
      int t;
      t = 0;
      while (rx_q.size() < exp_q.size() && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check({tag, "_beats"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check(tag, rx_q[i], exp_q[i]);
      check({tag, "_frame_cnt"}, frame_cnt, exp_frames);
      check({tag, "_frame_cnt_w"}, frame_cnt_w, exp_frames % 4);
   endtask

   task automatic reset_mid_cycle();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_data", m_data, 32'h0);
      check("rst_m_last", m_last, 1'b0);
      check("rst_frame_cnt", frame_cnt, 16'h0);
      check("rst_s_ready", s_ready, 1'b1);
      check("rst_w_outputs", {s_ready_w, m_valid_w, m_last_w, m_data_w, frame_cnt_w}, {3'b100, 34'h0});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_frames = 0;
   endtask

   initial begin
      logic [31:0] saved[$];
      logic [31:0] crc_nostall;
      logic [31:0] r;
      logic [31:0] r_flip;
      int          n_last;

      repeat (2) @(posedge clk);
      #1;
      reset_mid_cycle();

      // One-word all-zero frame.
      clear_all();
      stage.push_back(32'h0);
      add_frame();
      exp_frames++;
      drive(1, 0);
      drain_and_compare("one_word");

      // Seven payload words: the appended word must zero the downstream residue.
      clear_all();
      random_stage(7);
      saved = stage;
      add_frame();
      exp_frames++;
      drive(7, 0);
      drain_and_compare("seven_word");
      r = INIT;
      r_flip = INIT;
      for (int i = 0; i < rx_q.size(); i++) begin
         r      = ref_step(r, rx_q[i][31:0]);
         r_flip = ref_step(r_flip, (i == 3) ? (rx_q[i][31:0] ^ 32'h0000_0400) : rx_q[i][31:0]);
      end
      check("residue_zero", r, 32'h0);
      check("residue_flip_nonzero", r_flip != 32'h0, 1'b1);
      crc_nostall = exp_q[7][31:0];

      // Same payload with a five-cycle downstream stall mid-frame.
      clear_all();
      stage = saved;
      add_frame();
      exp_frames++;
      stall_start = 3;
      stall_len   = 5;
      drive(7, 0);
      stall_start = -1;
      stall_len   = 0;
      drain_and_compare("stall");
      if (rx_q.size() == 8) check("stall_crc_same", rx_q[7][31:0], crc_nostall);
      else check("stall_crc_present", rx_q.size(), 8);

      // Two back-to-back three-word frames with s_valid held high.
      clear_all();
      random_stage(3);
      add_frame();
      random_stage(3);
      add_frame();
      exp_frames += 2;
      drive(6, 8);
      drain_and_compare("b2b");
      for (int i = 1; i < rx_cyc.size(); i++) check("b2b_consecutive", rx_cyc[i] - rx_cyc[0], i);
      for (int i = 0; i < 8 && i < sr_q.size(); i++) check("b2b_s_ready", sr_q[i], (i == 3 || i == 7) ? 1'b0 : 1'b1);

      // Reset after two of four words, then a fresh one-word frame.
      clear_all();
      random_stage(4);
      add_frame();
      drive(2, 0);
      reset_mid_cycle();
      n_last = 0;
      foreach (rx_q[i]) if (rx_q[i][32]) n_last++;
      check("abort_no_crc", n_last, 0);
      clear_all();
      random_stage(1);
      add_frame();
      exp_frames++;
      drive(1, 0);
      drain_and_compare("after_abort");

      // Three more frames: the 2-bit counter wraps to zero at four.
      clear_all();
      for (int f = 0; f < 3; f++) begin
         random_stage(1 + f);
         add_frame();
      end
      exp_frames += 3;
      drive(6, 0);
      drain_and_compare("wrap");
      check("wrap_cnt_w_zero", frame_cnt_w, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
